// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache: one word per frame, combinational hits,
// single outstanding miss. Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache_direct #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    input  logic        flush
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    // state | meaning
    // IDLE  | serve hits combinationally; a miss latches its word address
    // FETCH | request latched word from memory, fill frame when iwait drops

    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state, state_nxt;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [31:0]      data_arr [SETS];
    logic [29:0]      miss_word;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic             lookup_hit;
    logic             hit;
    logic             start_miss;
    logic             fill;
    logic             unused_offset;

    assign req_tag    = imemaddr[31:IDX_W+2];
    assign req_idx    = imemaddr[IDX_W+1:2];
    assign fill_tag   = miss_word[29:IDX_W];
    assign fill_idx   = miss_word[IDX_W-1:0];
    assign unused_offset = ^imemaddr[1:0];

    assign lookup_hit = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    // flush masks the hit so the fetch stage never consumes a word being invalidated
    assign hit        = imemREN && !flush && lookup_hit;
    assign start_miss = (state == IDLE) && imemREN && !lookup_hit && !flush;
    assign fill       = (state == FETCH) && !iwait;

    always_comb begin
        state_nxt = state;
        ihit      = 1'b0;
        imemload  = 32'd0;
        iREN      = 1'b0;
        iaddr     = 32'd0;
        unique case (state)
            IDLE: begin
                ihit = hit;
                if (hit) imemload = data_arr[req_idx];
                if (start_miss) state_nxt = FETCH;
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_word, 2'b00};
                if (!iwait) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            miss_word <= '0;
            valid     <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_arr[i]  <= '0;
                data_arr[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (start_miss) miss_word <= imemaddr[31:2];
            if (flush) valid <= '0;
            // fill is written after the flush clear so a coincident fill survives
            if (fill) begin
                valid[fill_idx]    <= 1'b1;
                tag_arr[fill_idx]  <= fill_tag;
                data_arr[fill_idx] <= iload;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if ((state == IDLE) && hit) hit_count <= hit_count + 32'd1;
            if (start_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios plus randomized accesses checked
// against a frame-level model of a direct-mapped cache.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        flush;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;

    icache_direct dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iload(iload), .iwait(iwait), .flush(flush)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Model: each frame remembers which word address it holds and that word's data.
    bit          m_valid [16];
    logic [31:0] m_word  [16];
    logic [31:0] m_data  [16];

    function automatic int frame_of(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[frame_of(a)] && (m_word[frame_of(a)] == a / 4);
    endfunction

    // {hit_now, load_now, iren_now, fetch_cycles[3:0], iaddr_ok, hit_after, load_after}
    function automatic logic [71:0] m_expect(input logic [31:0] a, input logic [31:0] w, input int nw);
        if (m_hit(a))
            return {1'b1, m_data[frame_of(a)], 1'b0, 4'd0, 1'b1, 1'b0, 32'd0};
        return {1'b0, 32'd0, 1'b0, 4'(nw + 1), 1'b1, 1'b1, w};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_word[i]  = 0;
            m_data[i]  = 0;
        end
    endtask

    task automatic m_update(input logic [31:0] a, input logic [31:0] w, input int fk);
        if (!m_hit(a)) begin
            if (fk >= 0) m_clear();
            m_valid[frame_of(a)] = 1;
            m_word[frame_of(a)]  = a / 4;
            m_data[frame_of(a)]  = w;
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a / 4) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Drives one fetch request; on a miss plays the memory with nw stall cycles and
    // optionally pulses flush on fetch cycle fk. Only records what it observes.
    task automatic do_access(input logic [31:0] a, input logic [31:0] w, input int nw,
                             input int fk, output logic [71:0] obs);
        logic h0, ir0, aok, ph;
        logic [31:0] l0, pl;
        int fc;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1; flush = 1'b0; iload = $urandom;
        #1;
        h0 = ihit; l0 = imemload; ir0 = iREN;
        fc = 0; aok = 1'b1; ph = 1'b0; pl = 32'd0;
        @(posedge CLK);
        if (!h0) begin
            for (int k = 0; k <= nw; k++) begin
                @(negedge CLK);
                iwait = (k < nw);
                iload = (k < nw) ? $urandom : w;
                flush = (k == fk);
                #1;
                if (iREN) fc++;
                if (iaddr !== {a[31:2], 2'b00}) aok = 1'b0;
                @(posedge CLK);
            end
            @(negedge CLK);
            flush = 1'b0; iwait = 1'b1; iload = $urandom;
            #1;
            ph = ihit; pl = imemload;
            if (!ph) imemREN = 1'b0;
            @(posedge CLK);
        end
        obs = {h0, l0, ir0, 4'(fc), aok, ph, pl};
    endtask

    task automatic test_reset();
        RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; flush = 1'b0; iload = 32'hdead_beef;
        repeat (2) @(negedge CLK);
        #1;
        total++;
        if ({ihit, imemload} !== 33'd0) begin
            bad++; $display("FAIL reset_hit got=%h exp=0", {ihit, imemload});
        end
        total++;
        if ({iREN, iaddr} !== 33'd0) begin
            bad++; $display("FAIL reset_mem got=%h exp=0", {iREN, iaddr});
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total++;
        if (ihit !== 1'b0) begin
            bad++; $display("FAIL reset_cold_hit got=%b exp=0", ihit);
        end
        imemREN = 1'b0;
        m_reset();
`ifdef ICACHE_STATS_EN
        total++;
        if ({hit_count, miss_count} !== 64'd0) begin
            bad++; $display("FAIL reset_stats got=%h exp=0", {hit_count, miss_count});
        end
`endif
    endtask

    task automatic test_basic_miss();
        logic [71:0] obs, exp;
        exp = m_expect(32'h40, 32'h24020005, 3);
        do_access(32'h40, 32'h24020005, 3, -1, obs);
        m_update(32'h40, 32'h24020005, -1);
        total++;
        if (obs !== exp) begin
            bad++; $display("FAIL basic_miss got=%h exp=%h", obs, exp);
        end
        exp = m_expect(32'h42, 32'h0, 0);
        do_access(32'h42, 32'h0, 0, -1, obs);
        m_update(32'h42, 32'h0, -1);
        total++;
        if (obs !== exp) begin
            bad++; $display("FAIL offset_hit got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_conflict();
        logic [71:0] obs, exp;
        logic [31:0] addrs [3] = '{32'h80, 32'h40, 32'h40};
        logic [31:0] w;
        int nw;
        for (int i = 0; i < 3; i++) begin
            w = $urandom; nw = $urandom_range(0, 3);
            exp = m_expect(addrs[i], w, nw);
            do_access(addrs[i], w, nw, -1, obs);
            m_update(addrs[i], w, -1);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL conflict addr=%h got=%h exp=%h", addrs[i], obs, exp);
            end
        end
    endtask

    task automatic test_addr_change();
        logic [71:0] obs, exp;
        logic [31:0] w, w2;
        logic [31:0] addrs [2] = '{32'h40, 32'h100};
        w = mem_word(32'h80);
        exp = m_expect(32'h80, w, 1);
        do_access(32'h80, w, 1, -1, obs);
        m_update(32'h80, w, -1);
        total++;
        if (obs !== exp) begin
            bad++; $display("FAIL evict got=%h exp=%h", obs, exp);
        end
        w = 32'h1357_9bdf;
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; flush = 1'b0;
        #1;
        total++;
        if (ihit !== 1'b0) begin
            bad++; $display("FAIL chg_detect got=%b exp=0", ihit);
        end
        @(posedge CLK);
        for (int k = 0; k <= 2; k++) begin
            @(negedge CLK);
            imemaddr = 32'h100; imemREN = (k != 1); iwait = (k < 2);
            iload = (k < 2) ? $urandom : w;
            #1;
            total++;
            if ({iREN, iaddr} !== {1'b1, 32'h40}) begin
                bad++; $display("FAIL chg_iaddr cyc=%0d got=%h exp=%h", k, {iREN, iaddr}, {1'b1, 32'h40});
            end
            @(posedge CLK);
        end
        m_update(32'h40, w, -1);
        @(negedge CLK);
        imemREN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w2 = mem_word(addrs[i]);
            exp = m_expect(addrs[i], w2, 2);
            do_access(addrs[i], w2, 2, -1, obs);
            m_update(addrs[i], w2, -1);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL chg_after addr=%h got=%h exp=%h", addrs[i], obs, exp);
            end
        end
    endtask

    task automatic test_flush_idle();
        logic [71:0] obs, exp;
        logic [31:0] addrs [4] = '{32'h04, 32'h08, 32'h04, 32'h08};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                @(negedge CLK);
                imemREN = 1'b1; imemaddr = 32'h04; flush = 1'b1; iwait = 1'b1;
                #1;
                total++;
                if ({ihit, iREN} !== 2'b00) begin
                    bad++; $display("FAIL flush_idle_hit got=%b exp=00", {ihit, iREN});
                end
                @(posedge CLK);
                m_clear();
            end
            exp = m_expect(addrs[i], mem_word(addrs[i]), 1);
            do_access(addrs[i], mem_word(addrs[i]), 1, -1, obs);
            m_update(addrs[i], mem_word(addrs[i]), -1);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL flush_idle addr=%h got=%h exp=%h", addrs[i], obs, exp);
            end
        end
    endtask

    task automatic test_flush_fill();
        logic [71:0] obs, exp;
        logic [31:0] addrs [6] = '{32'h0C, 32'h0C, 32'h04, 32'h10, 32'h08, 32'h10};
        int fks [6] = '{2, -1, -1, 0, -1, -1};
        for (int i = 0; i < 6; i++) begin
            exp = m_expect(addrs[i], mem_word(addrs[i]), 2);
            do_access(addrs[i], mem_word(addrs[i]), 2, fks[i], obs);
            m_update(addrs[i], mem_word(addrs[i]), fks[i]);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL flush_fill addr=%h got=%h exp=%h", addrs[i], obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [71:0] obs, exp;
        logic [31:0] a;
        int nw, fk;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                @(negedge CLK);
                imemREN = 1'b0; imemaddr = $urandom; flush = 1'b0; iwait = 1'b1;
                #1;
                total++;
                if ({ihit, iREN, imemload} !== 34'd0) begin
                    bad++; $display("FAIL idle_no_req got=%h exp=0", {ihit, iREN, imemload});
                end
            end
            a  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            nw = $urandom_range(0, 3);
            fk = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nw) : -1;
            exp = m_expect(a, mem_word(a), nw);
            do_access(a, mem_word(a), nw, fk, obs);
            m_update(a, mem_word(a), fk);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL random addr=%h got=%h exp=%h", a, obs, exp);
            end
        end
    endtask

    task automatic test_rst_mid_fetch();
        logic [71:0] obs, exp;
        for (int pass = 0; pass < 2; pass++) begin
            exp = m_expect(32'h14, mem_word(32'h14), 1);
            do_access(32'h14, mem_word(32'h14), 1, -1, obs);
            m_update(32'h14, mem_word(32'h14), -1);
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL rst_access pass=%0d got=%h exp=%h", pass, obs, exp);
            end
            if (pass == 0) begin
                @(negedge CLK);
                imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1; flush = 1'b0;
                @(posedge CLK);
                @(negedge CLK);
                #1;
                total++;
                if ({iREN, iaddr} !== {1'b1, 32'h200}) begin
                    bad++; $display("FAIL rst_pre got=%h exp=%h", {iREN, iaddr}, {1'b1, 32'h200});
                end
                RST = 1'b1;
                #1;
                total++;
                if ({iREN, iaddr} !== 33'd0) begin
                    bad++; $display("FAIL rst_async got=%h exp=0", {iREN, iaddr});
                end
                imemREN = 1'b0;
                @(negedge CLK);
                RST = 1'b0;
                m_reset();
            end
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        logic [71:0] obs;
        logic [31:0] addrs [5] = '{32'h20, 32'h24, 32'h20, 32'h20, 32'h24};
        @(negedge CLK);
        RST = 1'b1; imemREN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        m_reset();
        for (int i = 0; i < 5; i++) begin
            do_access(addrs[i], mem_word(addrs[i]), 1, -1, obs);
            m_update(addrs[i], mem_word(addrs[i]), -1);
        end
        @(negedge CLK);
        imemREN = 1'b0;
        #1;
        total++;
        if ({miss_count, hit_count} !== {32'd2, 32'd5}) begin
            bad++; $display("FAIL stats got=%0d/%0d exp=2/5", miss_count, hit_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_miss();
        test_conflict();
        test_addr_change();
        test_flush_idle();
        test_flush_fill();
        test_random();
        test_rst_mid_fetch();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
